// File: rtl/mult_hilo_seq.sv
// Sequencer and HI/LO register pair around the iterative Booth multiplier.
// Optional: define MULT_HILO_ACCUM_EN to enable madd-style accumulation into HI:LO.
module mult_hilo_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MultStart,
  input  logic        AccMode,
  input  logic [31:0] OpA,
  input  logic [31:0] OpB,
  input  logic [1:0]  MtCtrl,
  input  logic [31:0] MtData,
  input  logic        MultDone,
  input  logic [31:0] MultHIIn,
  input  logic [31:0] MultLOIn,
  output logic        MultCtrl,
  output logic [31:0] MultA,
  output logic [31:0] MultB,
  output logic [31:0] HIOut,
  output logic [31:0] LOOut,
  output logic        Stall,
  output logic        OpDone,
  output logic        MultErr
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait,
    StCommit
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] cnt_inc;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [63:0]     prod_q, prod_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic            ctrl_q, ctrl_d;
  logic            stall_q, stall_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [63:0]     commit_val;

`ifdef MULT_HILO_ACCUM_EN
  logic acc_q, acc_d;

  // Accumulate wraps modulo 2^64; the carry out of bit 63 is dropped.
  always_comb begin
    commit_val = prod_q;
    if (acc_q) begin
      commit_val = {hi_q, lo_q} + prod_q;
    end
  end
`else
  logic unused_acc;
  assign unused_acc = AccMode;
  assign commit_val = prod_q;
`endif

  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = err_q;
`ifdef MULT_HILO_ACCUM_EN
    acc_d   = acc_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (MultStart) begin
          a_d     = OpA;
          b_d     = OpB;
          cnt_d   = '0;
          state_d = StLaunch;
`ifdef MULT_HILO_ACCUM_EN
          acc_d   = AccMode;
`endif
        end else begin
          if (MtCtrl[0]) hi_d = MtData;
          if (MtCtrl[1]) lo_d = MtData;
        end
      end
      // MultDone still carries the previous op's flag here, so it is not looked at.
      StLaunch: state_d = StWait;
      StWait: begin
        if (MultDone) begin
          prod_d  = {MultHIIn, MultLOIn};
          state_d = StCommit;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntW'(TIMEOUT_CYCLES)) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StCommit: begin
        {hi_d, lo_d} = commit_val;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    ctrl_d  = (state_d == StLaunch) || (state_d == StWait);
    stall_d = (state_d != StIdle);
    done_d  = (state_d == StCommit);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ctrl_q  <= 1'b0;
      stall_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MULT_HILO_ACCUM_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ctrl_q  <= ctrl_d;
      stall_q <= stall_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef MULT_HILO_ACCUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign MultCtrl = ctrl_q;
  assign MultA    = a_q;
  assign MultB    = b_q;
  assign HIOut    = hi_q;
  assign LOOut    = lo_q;
  assign Stall    = stall_q;
  assign OpDone   = done_q;
  assign MultErr  = err_q;

endmodule

// File: tb/tb_mult_hilo_seq.sv
// Bench for mult_hilo_seq: table vectors, directed corner sequences and random ops
// against a plain-arithmetic HI:LO model and a behavioural 33-cycle multiplier.
module tb_mult_hilo_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        MultStart;
  logic        AccMode;
  logic [31:0] OpA, OpB;
  logic [1:0]  MtCtrl;
  logic [31:0] MtData;
  logic        MultDone;
  logic [31:0] MultHIIn, MultLOIn;
  logic        MultCtrl;
  logic [31:0] MultA, MultB, HIOut, LOOut;
  logic        Stall, OpDone, MultErr;

  int total = 0;
  int bad   = 0;

  mult_hilo_seq #(.TIMEOUT_CYCLES(40)) dut (
    .clock    (clock),
    .reset    (reset),
    .MultStart(MultStart),
    .AccMode  (AccMode),
    .OpA      (OpA),
    .OpB      (OpB),
    .MtCtrl   (MtCtrl),
    .MtData   (MtData),
    .MultDone (MultDone),
    .MultHIIn (MultHIIn),
    .MultLOIn (MultLOIn),
    .MultCtrl (MultCtrl),
    .MultA    (MultA),
    .MultB    (MultB),
    .HIOut    (HIOut),
    .LOOut    (LOOut),
    .Stall    (Stall),
    .OpDone   (OpDone),
    .MultErr  (MultErr)
  );

  always #5 clock = ~clock;

  // Behavioural multiplier: initialises on the first cycle of a run, done after 33 run cycles,
  // and keeps its done flag while idle (the stale flag the sequencer must ignore).
  int   run_cnt   = 0;
  logic ctrl_prev = 1'b0;
  logic hang      = 1'b0;
  logic stale_force = 1'b0;
  logic [63:0] mprod;

  always @(posedge clock) begin
    if (MultCtrl && !ctrl_prev) run_cnt <= 1;
    else if (MultCtrl && run_cnt < 1000) run_cnt <= run_cnt + 1;
    ctrl_prev <= MultCtrl;
  end

  assign mprod    = longint'($signed(MultA)) * longint'($signed(MultB));
  assign MultHIIn = mprod[63:32];
  assign MultLOIn = mprod[31:0];
  assign MultDone = ((run_cnt >= 33) && !hang) || stale_force;

  logic [63:0] m_hilo;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic acc);
    OpA = a; OpB = b; AccMode = acc; MultStart = 1'b1;
    step();
    MultStart = 1'b0;
    OpA = $urandom; OpB = $urandom; AccMode = $urandom_range(0, 1);
  endtask

  // Waits for OpDone from cycle index n0, then steps into the following IDLE cycle.
  task automatic finish_op(input int n0, output int n);
    logic stall_bad;
    stall_bad = 1'b0;
    n = n0;
    while (!OpDone && n < 70) begin
      if (!Stall) stall_bad = 1'b1;
      step();
      n++;
    end
    if (!Stall) stall_bad = 1'b1;
    check("latency", 64'(n), 64'd36);
    check("stall_during_op", {63'd0, stall_bad}, 64'd0);
    step();
    check("stall_after_op", {62'd0, Stall, OpDone}, 64'd0);
  endtask

  task automatic model_op(input logic [31:0] a, input logic [31:0] b, input logic acc);
    logic [63:0] p;
    p = longint'($signed(a)) * longint'($signed(b));
`ifdef MULT_HILO_ACCUM_EN
    if (acc) m_hilo = m_hilo + p;
    else     m_hilo = p;
`else
    if (acc) m_hilo = p;
    else     m_hilo = p;
`endif
  endtask

  task automatic mt_write(input logic [1:0] ctrl, input logic [31:0] data);
    MtCtrl = ctrl; MtData = data;
    step();
    MtCtrl = 2'b00;
    if (ctrl[0]) m_hilo[63:32] = data;
    if (ctrl[1]) m_hilo[31:0]  = data;
  endtask

  initial begin
    int n;
    logic [31:0] ra, rb;
    logic racc;

    vecs[0] = '{32'd7,        32'd6,        32'h0000_0000, 32'd42};
    vecs[1] = '{-32'sd3,      32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[4] = '{32'h7FFF_FFFF, 32'd2,        32'h0000_0000, 32'hFFFF_FFFE};
    vecs[5] = '{32'h8000_0000, 32'd1,        32'hFFFF_FFFF, 32'h8000_0000};

    reset = 1'b1; MultStart = 0; AccMode = 0; OpA = 0; OpB = 0; MtCtrl = 0; MtData = 0;
    #23;
    check("reset_hilo", {HIOut, LOOut}, 64'd0);
    check("reset_flags", {60'd0, MultCtrl, Stall, OpDone, MultErr}, 64'd0);
    check("reset_ab", {MultA, MultB}, 64'd0);
    reset = 1'b0;
    m_hilo = 64'd0;
    step();

    // Table vectors (T1, T2 and extremes)
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, 1'b0);
      finish_op(2, n);
      check($sformatf("vec%0d_hilo", i), {HIOut, LOOut}, {vecs[i].hi, vecs[i].lo});
      check($sformatf("vec%0d_multa", i), {MultA, MultB}, {vecs[i].a, vecs[i].b});
      m_hilo = {vecs[i].hi, vecs[i].lo};
    end

    // T3: done held high through LAUNCH must not skip WAIT
    OpA = 32'd9; OpB = 32'd4; AccMode = 0; MultStart = 1'b1; stale_force = 1'b1;
    step();
    MultStart = 1'b0;
    step();
    stale_force = 1'b0;
    finish_op(3, n);
    check("stale_hilo", {HIOut, LOOut}, 64'd36);
    m_hilo = 64'd36;

    // T5: mt writes and collisions
    mt_write(2'b11, 32'd5);
    check("mt_both", {HIOut, LOOut}, {32'd5, 32'd5});
    mt_write(2'b01, 32'h11);
    check("mt_hi", {HIOut, LOOut}, {32'h11, 32'd5});
    mt_write(2'b10, 32'h22);
    check("mt_lo", {HIOut, LOOut}, {32'h11, 32'h22});
    MtCtrl = 2'b11; MtData = 32'd9;
    start_op(32'd2, 32'd3, 1'b0);
    MtCtrl = 2'b00;
    check("mt_dropped", {HIOut, LOOut}, {32'h11, 32'h22});
    step(); step(); step();
    MtCtrl = 2'b11; MtData = 32'h77; MultStart = 1'b1; OpA = 32'd100; OpB = 32'd100;
    step();
    MtCtrl = 2'b00; MultStart = 1'b0;
    check("mt_ignored_busy", {HIOut, LOOut}, {32'h11, 32'h22});
    finish_op(6, n);
    check("busy_start_ignored", {HIOut, LOOut, 32'd0}, {32'd0, 32'd6, 32'd0});
    check("busy_ab_held", {MultA, MultB}, {32'd2, 32'd3});
    step(); step();
    check("no_restart", {63'd0, Stall}, 64'd0);
    m_hilo = 64'd6;

    // T6: accumulate
    mt_write(2'b01, 32'd0);
    mt_write(2'b10, 32'hFFFF_FFFF);
    start_op(32'd1, 32'd1, 1'b1);
    finish_op(2, n);
`ifdef MULT_HILO_ACCUM_EN
    check("accum", {HIOut, LOOut}, {32'd1, 32'd0});
`else
    check("accum", {HIOut, LOOut}, {32'd0, 32'd1});
`endif
    model_op(32'd1, 32'd1, 1'b0);
`ifdef MULT_HILO_ACCUM_EN
    m_hilo = {32'd1, 32'd0};
`endif

    // Random ops and mt writes against the model
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        mt_write(2'($urandom_range(1, 3)), $urandom);
        check("rand_mt", {HIOut, LOOut}, m_hilo);
      end
      ra = $urandom; rb = $urandom; racc = 1'($urandom_range(0, 1));
      if (i % 4 == 0) ra = {{24{ra[7]}}, ra[7:0]};
      start_op(ra, rb, racc);
      finish_op(2, n);
      model_op(ra, rb, racc);
      check($sformatf("rand%0d_hilo", i), {HIOut, LOOut}, m_hilo);
    end

    // T4: timeout
    hang = 1'b1;
    start_op(32'd3, 32'd3, 1'b0);
    n = 2;
    while (Stall && n < 80) begin
      if (OpDone) n = 200;
      step();
      n++;
    end
    check("timeout_cycle", 64'(n), 64'd43);
    check("timeout_err", {62'd0, MultErr, MultCtrl}, 64'd2);
    check("timeout_hilo", {HIOut, LOOut}, m_hilo);
    hang = 1'b0;
    start_op(32'd4, 32'd5, 1'b0);
    finish_op(2, n);
    check("err_sticky", {HIOut, LOOut, 31'd0, MultErr}, {32'd0, 32'd20, 32'd1});

    // T7: reset during WAIT cycle 10
    start_op(32'd11, 32'd12, 1'b0);
    for (int k = 2; k < 12; k++) step();
    check("pre_reset_busy", {62'd0, Stall, MultCtrl}, 64'd3);
    #1 reset = 1'b1;
    #1;
    check("midreset_hilo", {HIOut, LOOut}, 64'd0);
    check("midreset_flags", {60'd0, MultCtrl, Stall, OpDone, MultErr}, 64'd0);
    check("midreset_ab", {MultA, MultB}, 64'd0);
    reset = 1'b0;
    step();
    start_op(32'd7, 32'd6, 1'b0);
    finish_op(2, n);
    check("post_reset_op", {HIOut, LOOut}, 64'd42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
